// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Instruction store for the 8-bit single-cycle processor. In load mode an
// operator keys program bytes in from switches (load_data) and a push-button
// (load_strobe). In run mode the store is read-only and serves the byte at the
// processor PC (read_address) on the registered instruction output.
// Runs on the fast board clock, ahead of the processor's clock divider.
//
// Parameters:
//   DEPTH        number of instruction bytes in the store (power of two, <=128)
//   FILL         byte returned for any address >= program length, and in LOAD
//   LOCKOUT_BITS width of the button debounce lockout counter
//                (lockout lasts about 2^LOCKOUT_BITS clocks)
//
// Ports:
//   clock          fast board clock, rising-edge active
//   clear          asynchronous active-low reset
//   mode_run       raw switch, 0 = load mode, 1 = run mode (asynchronous)
//   load_strobe    raw push-button, commits load_data (asynchronous, bouncy)
//   load_data      instruction byte to store
//   read_address   processor PC
//   instruction    registered byte at read_address (FILL outside the program)
//   load_pointer   next write address, zero-extended to 8 bits
//   program_length number of valid bytes stored
//   running        high while the FSM is in RUN
//   overflow       sticky: a write was attempted with the store full
// -----------------------------------------------------------------------------
module instruction_loader #(
   parameter int unsigned DEPTH        = 64,
   parameter logic [7:0]  FILL         = 8'h00,
   parameter int unsigned LOCKOUT_BITS = 16
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       mode_run,
   input  logic       load_strobe,
   input  logic [7:0] load_data,
   input  logic [7:0] read_address,
   output logic [7:0] instruction,
   output logic [7:0] load_pointer,
   output logic [7:0] program_length,
   output logic       running,
   output logic       overflow
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // synchroniser chains
   logic m1, m2;
   logic s1, s2, s3;
   logic write_pulse;

   logic [LOCKOUT_BITS-1:0] lockout_q;

   logic [7:0] pointer_q;
   logic [7:0] length_q;
   logic       overflow_q;
   logic [7:0] instruction_q;

   logic accept;       // debounced press seen in LOAD
   logic do_write;     // accepted press with room in the store
   logic do_overflow;  // accepted press with the store full
   logic exit_run;     // RUN -> LOAD transition this cycle

   logic [7:0] mem [DEPTH];

   // --------------------------------------------------------------------------
   // Input synchronisers and strobe edge detect
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         m1 <= 1'b0;
         m2 <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         m1 <= mode_run;
         m2 <= m1;
         s1 <= load_strobe;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign write_pulse = s2 & ~s3;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state and control
   // A pulse arriving on the cycle that leaves RUN is dropped because the
   // current state is still RUN; one arriving on the cycle that enters RUN
   // commits because the current state is still LOAD.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      exit_run = 1'b0;
      case (state_q)
         LOAD: begin
            accept = write_pulse && (lockout_q == '0);
            if (m2) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!m2) begin
               state_d  = LOAD;
               exit_run = 1'b1;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   assign do_write    = accept && (pointer_q < DEPTH_B);
   assign do_overflow = accept && !(pointer_q < DEPTH_B);

   // --------------------------------------------------------------------------
   // Debounce lockout: armed only by presses accepted in LOAD
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         lockout_q <= '0;
      end else if (accept) begin
         lockout_q <= '1;
      end else if (lockout_q != '0) begin
         lockout_q <= lockout_q - 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Write pointer, program length, overflow flag
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         pointer_q  <= '0;
         length_q   <= '0;
         overflow_q <= 1'b0;
      end else if (exit_run) begin
         pointer_q  <= '0;
         length_q   <= '0;
         overflow_q <= 1'b0;
      end else if (do_write) begin
         pointer_q  <= pointer_q + 8'd1;
         length_q   <= pointer_q + 8'd1;
      end else if (do_overflow) begin
         overflow_q <= 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Instruction store (contents survive reset and mode changes)
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (do_write) begin
         mem[pointer_q[AW-1:0]] <= load_data;
      end
   end

   // --------------------------------------------------------------------------
   // Registered read. The explicit DEPTH bound keeps high addresses from
   // aliasing onto low store entries.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         instruction_q <= FILL;
      end else if ((state_q == RUN) && (read_address < length_q) &&
                   (read_address < DEPTH_B)) begin
         instruction_q <= mem[read_address[AW-1:0]];
      end else begin
         instruction_q <= FILL;
      end
   end

   assign instruction    = instruction_q;
   assign load_pointer   = pointer_q;
   assign program_length = length_q;
   assign overflow       = overflow_q;
   assign running        = (state_q == RUN);

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Instruction-side companion to the 8-bit single-cycle processor. It holds the program in a small on-chip instruction store and serves the byte at the processor's `read_address` to its `instruction` input. In load mode, an operator keys instructions in one byte at a time from switches and a push-button; in run mode, the store is read-only and feeds the processor. It runs on the fast board clock, upstream of the processor's internal clock divider.

## Interface
Parameters:
- DEPTH, 64, number of instruction bytes in the store (power of two, ≤128)
- FILL, 8'h00, byte returned for any address ≥ program length

Ports:
- clock  in  1  fast board clock; all state updates on the rising edge
- clear  in  1  asynchronous, active-low reset
- mode_run  in  1  raw switch: 0 = load mode, 1 = run mode; asynchronous to clock
- load_strobe  in  1  raw push-button: commits `load_data`; asynchronous, not debounced upstream
- load_data  in  8  instruction byte to store
- read_address  in  8  processor PC
- instruction  out  8  byte at `read_address`, registered
- load_pointer  out  8  next write address, zero-extended
- program_length  out  8  number of valid bytes stored
- running  out  1  high in RUN state
- overflow  out  1  sticky flag: a write was attempted with the store full

## Operation
- Synchronisers:
  - `mode_run` passes through 2 flops (m1, m2).
  - `load_strobe` passes through 2 flops (s1, s2) plus an edge register s3.
  - `write_pulse` = s2 & ~s3, one clock wide per button press.
- Debounce:
  - After a `write_pulse`, further pulses are ignored for 2^16 clocks.
  - A 16-bit lockout counter is loaded on the pulse and counts down to 0.
- FSM states: LOAD, RUN.
  - LOAD → RUN when m2 = 1.
  - RUN → LOAD when m2 = 0.
  - On the RUN → LOAD transition, `load_pointer` and `program_length` are cleared to 0 and `overflow` is cleared. Store contents are kept but are invisible because length = 0.
- Write, in LOAD only, on a `write_pulse` outside lockout:
  - If pointer < DEPTH: mem[pointer] ← `load_data` (sampled that cycle), pointer ← pointer+1, length ← pointer+1.
  - If pointer = DEPTH: no write, `overflow` ← 1.
  - Pointer saturates at DEPTH and never wraps.
- `write_pulse` in RUN is discarded and does not arm the lockout.
- Read, registered each clock:
  - In RUN: `instruction` ← mem[`read_address`] if `read_address` < `program_length`, else FILL.
  - In LOAD: `instruction` ← FILL, so the processor executes filler while a program is being entered.
- Width rules:
  - `read_address` compares as unsigned 8-bit.
  - Addresses ≥ DEPTH always return FILL. Addresses never alias modulo DEPTH.
- Reset (clear = 0), asynchronous:
  - State ← LOAD; pointer, length ← 0; `overflow` ← 0.
  - `instruction` ← FILL; `running` ← 0.
  - All synchroniser flops and the lockout counter ← 0.
  - Store contents are not reset.

## Timing
- Mode change:
  - An edge on `mode_run` before clock edge 1 changes the state register at edge 3.
  - `running` follows the state register directly, so it changes at edge 3.
- Button press:
  - A rising edge of `load_strobe` before clock edge 1 makes `write_pulse` high between edges 2 and 3.
  - Memory, pointer and length update at edge 3.
  - `load_data` must be stable from edge 2 through edge 3.
- Read latency:
  - `instruction` reflects `read_address` one clock later.
  - The processor's slow clock period far exceeds this, so one-cycle latency is transparent to it.
- Simultaneous events:
  - `write_pulse` in the same cycle as a LOAD → RUN transition: the write commits, because the state is LOAD at that edge.
  - `write_pulse` in the same cycle as a RUN → LOAD transition: the pulse is discarded and the clears apply.
- Reset mid-write: an asserted `clear` overrides any pending pulse. No partial pointer update occurs.

## Test plan
- Reset, then check the idle outputs: with mode_run = 0 and any `read_address`, `instruction` = 8'h00, `running` = 0, `load_pointer` = 0, `program_length` = 0, `overflow` = 0.
- Load and run: press 3 times with data 8'h41, 8'h86, 8'hC3 (presses spaced beyond lockout), then mode_run = 1.
  - Before the mode change: `load_pointer` = 3, `program_length` = 3.
  - After the mode change, `running` rises 3 clocks later.
  - Reads at addresses 0, 1, 2, 3 return 8'h41, 8'h86, 8'hC3, 8'h00, each one clock after the address is applied.
- Debounce: apply a strobe that bounces 5 times within 1000 clocks, then hold it. Pointer advances by exactly 1.
- Overflow: press DEPTH+1 times.
  - Pointer and length stop at DEPTH; `overflow` = 1.
  - mem[DEPTH-1] holds the last accepted byte; the extra press writes nothing.
- Mode round-trip: after the load-and-run scenario, set mode_run 1 → 0.
  - Pointer, length and `overflow` = 0.
  - A read of address 0 in a subsequent RUN with no new loads returns 8'h00.
  - A press while mode_run = 1 changes nothing.
- Asynchronous reset: assert clear mid-press, between edges 2 and 3 of the press. Pointer stays 0 and all outputs go to their reset values without waiting for a clock edge.
